// File: rtl/split_sched_pkg.sv
// Shared types and default parameter values for the split checker sequencer.
package split_sched_pkg;

    localparam int unsigned NumSplitsDef = 8;
    localparam int unsigned CandWDef     = 38;
    localparam int unsigned TryWDef      = 10;
    localparam int unsigned StepDef      = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StEval,
        StCheck,
        StDone
    } state_t;

endpackage

// File: rtl/split_first_fail.sv
// Lowest-set-bit priority encoder; reports 0 when no bit is set.
module split_first_fail #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/split_eval_sched.sv
// Steps a candidate across a bank of split checkers until all enabled splits
// pass or the try budget is exhausted.
module split_eval_sched
    import split_sched_pkg::*;
#(
    parameter int unsigned NUM_SPLITS = NumSplitsDef,
    parameter int unsigned CAND_W     = CandWDef,
    parameter int unsigned TRY_W      = TryWDef,
    parameter int unsigned STEP       = StepDef
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CAND_W-1:0]             seed,
    input  logic [NUM_SPLITS-1:0]         mask,
    output logic [CAND_W-1:0]             cand,
    input  logic [NUM_SPLITS-1:0]         split_ok,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [CAND_W-1:0]             result,
    output logic [TRY_W-1:0]              tries,
    output logic [$clog2(NUM_SPLITS)-1:0] first_fail
);

    localparam int unsigned FfW = $clog2(NUM_SPLITS);

    state_t                state_q;
    logic [CAND_W-1:0]     seed_q;
    logic [NUM_SPLITS-1:0] mask_q;
    logic [NUM_SPLITS-1:0] ok_q;
    logic [TRY_W-1:0]      cnt_q;
    logic [FfW-1:0]        ff_idx;
    logic                  pass;
    logic                  last_try;

    assign pass     = &(ok_q | ~mask_q);
    assign last_try = &cnt_q;

    split_first_fail #(
        .N (NUM_SPLITS),
        .W (FfW)
    ) u_first_fail (
        .vec (~ok_q & mask_q),
        .idx (ff_idx)
    );

    // The search counter stays internal so an abort leaves the published
    // tries value from the last completed search untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            seed_q     <= '0;
            mask_q     <= '0;
            ok_q       <= '0;
            cnt_q      <= '0;
            cand       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            result     <= '0;
            tries      <= '0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state_q != StIdle) begin
                state_q <= StIdle;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            seed_q  <= seed;
                            mask_q  <= mask;
                            busy    <= 1'b1;
                            state_q <= StLoad;
                        end
                    end
                    StLoad: begin
                        cand    <= seed_q;
                        cnt_q   <= '0;
                        state_q <= StEval;
                    end
                    StEval: begin
                        ok_q    <= split_ok;
                        state_q <= StCheck;
                    end
                    StCheck: begin
                        if (pass || last_try) begin
                            found      <= pass;
                            result     <= cand;
                            tries      <= cnt_q;
                            first_fail <= ff_idx;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state_q    <= StDone;
                        end else begin
                            cand    <= cand + CAND_W'(STEP);
                            cnt_q   <= cnt_q + TRY_W'(1);
                            state_q <= StEval;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_split_eval_sched.sv
// Randomised scoreboard bench for split_eval_sched with a reduced try budget.
module tb_split_eval_sched;

    localparam int unsigned NS     = 8;
    localparam int unsigned CW     = 38;
    localparam int unsigned TW     = 4;
    localparam int unsigned BUDGET = 16;

    typedef struct {
        logic          found;
        logic [CW-1:0] result;
        int            tries;
        int            ff;
        int            done_cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] seed;
    logic [NS-1:0] mask;
    logic [CW-1:0] cand;
    logic [NS-1:0] split_ok;
    logic          busy;
    logic          done;
    logic          found;
    logic [CW-1:0] result;
    logic [TW-1:0] tries;
    logic [2:0]    first_fail;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   mode     = 0;
    exp_t q[$];
    exp_t last_e;

    split_eval_sched #(
        .NUM_SPLITS (NS),
        .CAND_W     (CW),
        .TRY_W      (TW),
        .STEP       (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .mask       (mask),
        .cand       (cand),
        .split_ok   (split_ok),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .result     (result),
        .tries      (tries),
        .first_fail (first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Checker bank model: mode 0 hash, 1 "!= magic", 2 split 3 always fails, 3 "== 0".
    function automatic logic [NS-1:0] ok_vec(input int md, input logic [CW-1:0] c);
        logic [NS-1:0] v;
        logic [63:0]   x;
        v = '0;
        for (int i = 0; i < int'(NS); i++) begin
            case (md)
                0: begin
                    x    = {26'b0, c} + 64'(i * 7);
                    v[i] = (x % 64'(i + 2)) != 0;
                end
                1:       v[i] = (c != 38'h34d5a910c);
                2:       v[i] = (i != 3);
                default: v[i] = (c == '0);
            endcase
        end
        return v;
    endfunction

    always_comb split_ok = ok_vec(mode, cand);

    function automatic exp_t predict(input logic [CW-1:0] s, input logic [NS-1:0] m,
                                     input int md);
        exp_t          e;
        logic [CW-1:0] c;
        logic [NS-1:0] bad;
        e.found = 1'b0; e.result = '0; e.tries = 0; e.ff = 0; e.done_cyc = 0;
        for (int t = 0; t < int'(BUDGET); t++) begin
            c   = s + CW'(t);
            bad = ~ok_vec(md, c) & m;
            if (bad == '0 || t == int'(BUDGET) - 1) begin
                e.found  = (bad == '0);
                e.result = c;
                e.tries  = t;
                for (int i = int'(NS) - 1; i >= 0; i--) if (bad[i]) e.ff = i;
                e.done_cyc = 4 + 2 * t;
                return e;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("found",      64'(found),      64'(e.found));
                check("result",     64'(result),     64'(e.result));
                check("tries",      64'(tries),      64'(e.tries));
                check("first_fail", 64'(first_fail), 64'(e.ff));
                check("done_cycle", 64'(cyc),        64'(e.done_cyc));
                check("busy_in_done", 64'(busy),     64'(0));
            end
        end
    end

    // Called right after a posedge; leaves at #1 after the sampling edge.
    task automatic issue(input logic [CW-1:0] s, input logic [NS-1:0] m, input bit push);
        exp_t e;
        #1;
        start = 1'b1; seed = s; mask = m;
        if (push) begin
            e = predict(s, m, mode);
            e.done_cyc += cyc;
            q.push_back(e);
            last_e = e;
        end
        @(posedge clk); #1;
        start = 1'b0;
        seed  = {$urandom, $urandom};
        mask  = NS'($urandom);
    endtask

    // Returns at the posedge that leaves DONE.
    task automatic wait_done(input int n0);
        int k;
        k = 0;
        while (done_cnt <= n0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt <= n0) begin
            check("timeout", 64'(done_cnt), 64'(n0 + 1));
            q.delete();
        end
    endtask

    task automatic run(input int md, input logic [CW-1:0] s, input logic [NS-1:0] m);
        int n0;
        mode = md;
        n0   = done_cnt;
        issue(s, m, 1'b1);
        wait_done(n0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cand"},   64'(cand),       64'(0));
        check({tag, "_busy"},   64'(busy),       64'(0));
        check({tag, "_done"},   64'(done),       64'(0));
        check({tag, "_found"},  64'(found),      64'(0));
        check({tag, "_result"}, 64'(result),     64'(0));
        check({tag, "_tries"},  64'(tries),      64'(0));
        check({tag, "_ff"},     64'(first_fail), 64'(0));
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; mask = '0;
        last_e.found = 1'b0; last_e.result = '0; last_e.tries = 0; last_e.ff = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);

        run(1, 38'h34d5a910c, 8'h01);
        run(1, 38'h0, 8'h01);
        run(2, 38'h1234, 8'h08);
        run(3, 38'h3FFFFFFFFF, 8'hFF);
        run(0, {$urandom, $urandom}, 8'h00);

        // Abort during the third EVAL cycle.
        mode = 2;
        n0   = done_cnt;
        issue(38'h55, 8'h08, 1'b0);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy",   64'(busy),       64'(0));
        check("abort_found",  64'(found),      64'(last_e.found));
        check("abort_result", 64'(result),     64'(last_e.result));
        check("abort_tries",  64'(tries),      64'(last_e.tries));
        check("abort_ff",     64'(first_fail), 64'(last_e.ff));
        repeat (40) @(posedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(n0));
        run(1, 38'h34d5a910c, 8'h01);

        // Asynchronous reset during CHECK.
        mode = 2;
        n0   = done_cnt;
        issue(38'h2AB, 8'h08, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        check("reset_no_done", 64'(done_cnt), 64'(n0));
        last_e.found = 1'b0; last_e.result = '0; last_e.tries = 0; last_e.ff = 0;
        run(1, 38'h34d5a910c, 8'h01);

        // Randomised back-to-back searches with ignored starts while busy.
        for (int r = 0; r < 40; r++) begin
            mode = 0;
            n0   = done_cnt;
            issue({$urandom, $urandom}, NS'($urandom), 1'b1);
            if (r % 3 == 0) begin
                @(posedge clk); #1;
                start = 1'b1; seed = {$urandom, $urandom}; mask = NS'($urandom);
                @(posedge clk); #1;
                start = 1'b0;
            end
            wait_done(n0);
        end

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
